// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and receiver.
// Contents: transmitter state enumeration, error codes reported on
// tx_err_code, common keyboard command bytes, and an odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ      = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAIT_REL = 3'd5
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser with falling-edge detect for one PS/2 line.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (flops reset to the idle-high level)
//   line  raw asynchronous line
//   sync  synchronised line level
//   fall  one-cycle pulse when sync goes 1 -> 0
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to 1 so an idle (pulled-up) line does not produce a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts one byte (LSB first, odd parity, released stop bit) on the
// device-generated clock, checks the device ACK and waits for bus release.
// Both lines are driven open-drain through output enables.
//
// Optional build macro: PS2_TX_RETRY_EN -- on the first NACK/timeout the
// latched byte is resent once; only a second failure reports tx_err.
//
// Ports:
//   m_clock      system clock
//   p_reset      synchronous active-high reset
//   tx_data      byte to send, latched on acceptance
//   tx_start     single-cycle request, accepted only in IDLE
//   tx_busy      high while a transfer is in progress
//   tx_done      one-cycle pulse: byte acknowledged by the device
//   tx_err       one-cycle pulse: transfer failed
//   tx_err_code  failure reason, held until the next tx_err
//   rx_inhibit   tells the receiver to drop its frame (equals tx_busy)
//   ps2_clk_in   raw CLK line
//   ps2_dat_in   raw DATA line
//   ps2_clk_oe   1 pulls CLK low
//   ps2_dat_oe   1 pulls DATA low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | CLK held low for INHIBIT_CYCLES
// REQ      | CLK and DATA low for one cycle (start bit)
// SHIFT    | CLK released; data/parity/stop updated on device falling edges
// ACK      | sample DATA on the next falling edge (0 = ACK)
// WAIT_REL | wait for both lines high, then report done
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk  (m_clock),
    .rst  (p_reset),
    .line (ps2_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk  (m_clock),
    .rst  (p_reset),
    .line (ps2_dat_in),
    .sync (dat_sync),
    .fall (dat_fall_unused)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [3:0]       n_q, n_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             retry_q, retry_d;
  logic             fail;
  logic [1:0]       fail_code;

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      n_q      <= '0;
      inh_q    <= '0;
      to_q     <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      n_q      <= n_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    n_d       = n_q;
    inh_d     = inh_q;
    to_d      = (to_q != '0) ? to_q - TO_ONE : to_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    retry_d   = retry_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        retry_d  = 1'b0;
        // The done/err pulse cycle already shows IDLE in the state register,
        // but the transfer is only finished once the pulse has gone.
        if (tx_start && !done_q && !err_q) begin
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          inh_d    = INH_LOAD;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_q == '0) begin
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end else begin
          inh_d = inh_q - INH_ONE;
        end
      end

      REQ: begin
        clk_oe_d = 1'b0;
        n_d      = '0;
        to_d     = TO_LOAD;
        state_d  = SHIFT;
      end

      SHIFT: begin
        if (clk_fall) begin
          to_d = TO_LOAD;
          if (n_q < 4'd8) begin
            dat_oe_d = ~data_q[n_q[2:0]];
            n_d      = n_q + 4'd1;
          end else if (n_q == 4'd8) begin
            dat_oe_d = ~par_q;
            n_d      = n_q + 4'd1;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end else if (to_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      ACK: begin
        if (clk_fall) begin
          to_d = TO_LOAD;
          if (dat_sync) begin
            fail      = 1'b1;
            fail_code = ERR_NACK;
          end else begin
            state_d = WAIT_REL;
          end
        end else if (to_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      WAIT_REL: begin
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (clk_fall) begin
          to_d = TO_LOAD;
        end else if (to_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = IDLE;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d  = 1'b1;
        inh_d    = INH_LOAD;
        clk_oe_d = 1'b1;
        state_d  = INHIBIT;
      end else begin
        err_d  = 1'b1;
        code_d = fail_code;
      end
`else
      err_d  = 1'b1;
      code_d = fail_code;
`endif
    end
  end

  assign tx_busy     = (state_q != IDLE);
  assign rx_inhibit  = tx_busy;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign tx_err_code = code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH        = 40;
  localparam int TO         = 300;
  localparam int HALF       = 25;
  localparam int START_DLY  = 30;
  localparam int DET_LIMIT  = TO + INH + 200;
  localparam int END_LIMIT  = 2000;
  localparam int M_ACK      = 0;
  localparam int M_NACK     = 1;
  localparam int M_SILENT   = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int NATT = 2;
`else
  localparam int NATT = 1;
`endif

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic [1:0] tx_err_code;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_rel = 1'b1;
  logic       dev_dat_rel = 1'b1;

  always #5 m_clock = ~m_clock;

  // Open-drain bus: a line is high only when neither side pulls it.
  assign ps2_clk_in = dev_clk_rel & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat_rel & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_err_code (tx_err_code),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Passive monitor: pulse counts, inhibit-phase length, protocol violations.
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         inh_cnt  = 0;
  int         viol_cnt = 0;
  logic [1:0] last_code = 2'b00;

  always @(negedge m_clock) begin
    if (tx_done) done_cnt++;
    if (tx_err) begin
      err_cnt++;
      last_code = tx_err_code;
    end
    if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
    if (tx_done && tx_err) viol_cnt++;
    if (rx_inhibit !== tx_busy) viol_cnt++;
    if ((tx_done || tx_err) && (ps2_clk_oe || ps2_dat_oe)) viol_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    int         m1;
    int         m2;
    string      nm;
  } vec_t;

  typedef struct {
    logic [10:0] frame;
    logic        chk_frame;
    logic        done;
    logic [1:0]  code;
    int          inh;
  } exp_t;

  exp_t exp_q[$];

  // Device model: waits for the request, then clocks 11 edges, capturing
  // start, 8 data, parity and stop from the DATA line before each rise.
  task automatic device(input int mode, output logic [10:0] bits, output logic ok);
    int k = 0;
    bits = '0;
    ok   = 1'b0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && k < DET_LIMIT) begin
      @(negedge m_clock);
      k++;
    end
    if (k >= DET_LIMIT) return;
    ok = 1'b1;
    if (mode == M_SILENT) return;
    repeat (START_DLY) @(negedge m_clock);
    bits[0] = ps2_dat_in;
    for (int e = 1; e <= 10; e++) begin
      dev_clk_rel = 1'b0;
      repeat (HALF) @(negedge m_clock);
      bits[e] = ps2_dat_in;
      dev_clk_rel = 1'b1;
      repeat (HALF) @(negedge m_clock);
    end
    if (mode == M_ACK) dev_dat_rel = 1'b0;
    repeat (2) @(negedge m_clock);
    dev_clk_rel = 1'b0;
    repeat (HALF) @(negedge m_clock);
    dev_clk_rel = 1'b1;
    repeat (2) @(negedge m_clock);
    dev_dat_rel = 1'b1;
  endtask

  task automatic run_txn(input logic [7:0] d, input int m1, input int m2, input string nm);
    exp_t        e;
    exp_t        got;
    logic [10:0] obs, obs2;
    logic        ok, ok2;
    int          d0, e0, i0, k, fm, att;
    d0  = done_cnt;
    e0  = err_cnt;
    i0  = inh_cnt;
    fm  = m1;
    att = 1;
`ifdef PS2_TX_RETRY_EN
    if (m1 != M_ACK) begin
      fm  = m2;
      att = 2;
    end
`endif
    e.frame     = {1'b1, ~^d, d, 1'b0};
    e.chk_frame = (m1 != M_SILENT);
    e.done      = (fm == M_ACK);
    e.code      = (fm == M_NACK) ? 2'b10 : 2'b01;
    e.inh       = att * INH;
    exp_q.push_back(e);

    @(negedge m_clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge m_clock);
    tx_start = 1'b0;
    device(m1, obs, ok);
    check({nm, "_req_seen"}, ok, 1'b1);
    if (att == 2) begin
      device(m2, obs2, ok2);
      check({nm, "_retry_req_seen"}, ok2, 1'b1);
    end
    k = 0;
    while ((done_cnt - d0) + (err_cnt - e0) == 0 && k < END_LIMIT) begin
      @(negedge m_clock);
      k++;
    end
    check({nm, "_end_in_time"}, (k < END_LIMIT), 1'b1);
    repeat (5) @(negedge m_clock);

    got = exp_q.pop_front();
    if (got.chk_frame) check({nm, "_frame"}, obs, got.frame);
    check({nm, "_done_pulses"}, done_cnt - d0, got.done ? 1 : 0);
    check({nm, "_err_pulses"}, err_cnt - e0, got.done ? 0 : 1);
    if (!got.done) check({nm, "_err_code"}, last_code, got.code);
    check({nm, "_inhibit_cycles"}, inh_cnt - i0, got.inh);
    check({nm, "_busy_after"}, tx_busy, 1'b0);
  endtask

  task automatic wait_shift(input string nm);
    int k = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && k < DET_LIMIT) begin
      @(negedge m_clock);
      k++;
    end
    check({nm, "_shift_seen"}, (k < DET_LIMIT), 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];

  initial begin
    int d0, e0, k;
    logic [10:0] obs;
    logic        ok;

    vecs[0] = '{data: CMD_SET_LED, m1: M_ACK,    m2: M_ACK,    nm: "ed_ack"};
    vecs[1] = '{data: 8'h00,       m1: M_ACK,    m2: M_ACK,    nm: "00_ack"};
    vecs[2] = '{data: CMD_RESET,   m1: M_ACK,    m2: M_ACK,    nm: "ff_ack"};
    vecs[3] = '{data: 8'h5A,       m1: M_NACK,   m2: M_NACK,   nm: "5a_nack"};
    vecs[4] = '{data: 8'h81,       m1: M_SILENT, m2: M_SILENT, nm: "81_silent"};

    repeat (4) @(negedge m_clock);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_dat_oe", ps2_dat_oe, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    check("rst_code", tx_err_code, 2'b00);
    check("rst_rx_inhibit", rx_inhibit, 1'b0);
    p_reset = 1'b0;
    repeat (3) @(negedge m_clock);

    for (int i = 0; i < 5; i++) run_txn(vecs[i].data, vecs[i].m1, vecs[i].m2, vecs[i].nm);

    // Timeout latency measured from each SHIFT entry.
    d0 = err_cnt;
    @(negedge m_clock);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge m_clock);
    tx_start = 1'b0;
    for (int a = 0; a < NATT; a++) begin
      wait_shift("to");
      k = 0;
      while (!tx_err && !ps2_clk_oe && k < TO + 50) begin
        @(negedge m_clock);
        k++;
      end
      check("to_latency", k, TO);
    end
    check("to_err_pulse", tx_err, 1'b1);
    check("to_code", tx_err_code, 2'b01);
    check("to_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    repeat (3) @(negedge m_clock);
    check("to_single_err", err_cnt - d0, 1);

    // A second request mid-frame must be dropped; the frame stays 0xA5.
    fork
      run_txn(8'hA5, M_ACK, M_ACK, "a5_ignore_start");
      begin
        repeat (INH + 60) @(negedge m_clock);
        tx_data  = CMD_RESET;
        tx_start = 1'b1;
        @(negedge m_clock);
        tx_start = 1'b0;
      end
    join
    repeat (5) @(negedge m_clock);
    check("ignore_not_queued", tx_busy, 1'b0);

    // tx_start coinciding with the tx_done pulse is dropped.
    d0 = done_cnt;
    @(negedge m_clock);
    tx_data  = 8'h96;
    tx_start = 1'b1;
    @(negedge m_clock);
    tx_start = 1'b0;
    fork
      device(M_ACK, obs, ok);
      begin
        k = 0;
        while (!tx_done && k < DET_LIMIT + END_LIMIT) begin
          @(negedge m_clock);
          k++;
        end
        tx_data  = 8'h11;
        tx_start = 1'b1;
        @(negedge m_clock);
        tx_start = 1'b0;
      end
    join
    repeat (3) @(negedge m_clock);
    check("coinc_done_seen", done_cnt - d0, 1);
    check("coinc_start_dropped", tx_busy, 1'b0);
    check("coinc_frame", obs, {1'b1, ~^8'h96, 8'h96, 1'b0});

    // Reset in the middle of SHIFT releases both lines with no pulses.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge m_clock);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge m_clock);
    tx_start = 1'b0;
    wait_shift("rst_mid");
    repeat (START_DLY) @(negedge m_clock);
    for (int e = 0; e < 3; e++) begin
      dev_clk_rel = 1'b0;
      repeat (HALF) @(negedge m_clock);
      dev_clk_rel = 1'b1;
      repeat (HALF) @(negedge m_clock);
    end
    check("rst_mid_busy_before", tx_busy, 1'b1);
    p_reset = 1'b1;
    @(negedge m_clock);
    check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_mid_busy", tx_busy, 1'b0);
    p_reset = 1'b0;
    repeat (20) @(negedge m_clock);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_err", err_cnt - e0, 0);

`ifdef PS2_TX_RETRY_EN
    run_txn(CMD_SET_LED, M_NACK, M_ACK, "retry_ok");
`endif

    check("protocol_violations", viol_cnt, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
